disp_timing_gen_prog: RTL and testbench

Runtime-programmable display timing generator, the successor to the fixed-parameter sync-generator FSM. It produces vsync/hsync/de plus active-pixel coordinates and a partial-display window enable (o_pde) that feed frame_memory_control and downstream sinks. Timing values are register inputs, shadowed at frame boundaries, so resolution and porches can change without reset.

---
 rtl/disp_timing_gen_prog_pkg.sv | 33 +++
 rtl/disp_seg_cnt.sv | 83 ++++++++
 rtl/disp_timing_gen_prog.sv | 159 +++++++++++++++
 tb/tb_disp_timing_gen_prog.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_timing_gen_prog_pkg.sv
// Shared types for the programmable display timing generator: per-axis segment
// states and the shadowed timing/window configuration record.
package disp_timing_gen_prog_pkg;

  localparam int TG_CNT_W = 11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PULSE = 3'd1,
    BP    = 3'd2,
    ACT   = 3'd3,
    FP    = 3'd4
  } seg_state_t;

  typedef seg_state_t Vstate_t;
  typedef seg_state_t Hstate_t;

  typedef struct packed {
    logic [TG_CNT_W-1:0] vpulse;
    logic [TG_CNT_W-1:0] vbp;
    logic [TG_CNT_W-1:0] vres;
    logic [TG_CNT_W-1:0] vfp;
    logic [TG_CNT_W-1:0] hpulse;
    logic [TG_CNT_W-1:0] hbp;
    logic [TG_CNT_W-1:0] hres;
    logic [TG_CNT_W-1:0] hfp;
    logic [TG_CNT_W-1:0] psc;
    logic [TG_CNT_W-1:0] pec;
    logic [TG_CNT_W-1:0] sr;
    logic [TG_CNT_W-1:0] er;
  } timing_cfg_t;

endpackage

// File: rtl/disp_seg_cnt.sv
// Single-axis segment sequencer: PULSE -> BP -> ACT -> FP -> PULSE, skipping
// empty segments; pulse and active lengths of 0 behave as 1.
module disp_seg_cnt
  import disp_timing_gen_prog_pkg::*;
#(
  parameter int W = TG_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         advance,
  input  logic         halt,
  input  logic [W-1:0] len_pulse,
  input  logic [W-1:0] len_bp,
  input  logic [W-1:0] len_act,
  input  logic [W-1:0] len_fp,
  output seg_state_t   state,
  output seg_state_t   state_nxt,
  output logic [W-1:0] index_nxt,
  output logic         last
);

  seg_state_t   state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] seg_len;
  logic         seg_last, wrap_pt;

  // Kept apart from the next-state block so the other axis can use 'last'
  // without forming a combinational loop through 'halt'.
  always_comb begin
    seg_len = W'(1);
    case (state_q)
      PULSE:   seg_len = (len_pulse == '0) ? W'(1) : len_pulse;
      BP:      seg_len = len_bp;
      ACT:     seg_len = (len_act == '0) ? W'(1) : len_act;
      FP:      seg_len = len_fp;
      default: seg_len = W'(1);
    endcase
    seg_last = (cnt_q == seg_len - W'(1));
    wrap_pt  = seg_last && ((state_q == FP) || ((state_q == ACT) && (len_fp == '0)));
    last     = advance && wrap_pt;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = PULSE;
        cnt_d   = '0;
      end
    end else if (advance) begin
      if (!seg_last) begin
        cnt_d = cnt_q + W'(1);
      end else begin
        cnt_d = '0;
        if (wrap_pt)
          state_d = halt ? IDLE : PULSE;
        else if (state_q == PULSE)
          state_d = (len_bp != '0) ? BP : ACT;
        else if (state_q == BP)
          state_d = ACT;
        else
          state_d = FP;
      end
    end
    index_nxt = (state_d == ACT) ? cnt_d : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state     = state_q;
  assign state_nxt = state_d;

endmodule

// File: rtl/disp_timing_gen_prog.sv
// Runtime-programmable display timing generator with frame-boundary shadowing.
// Optional gradient test-pattern output o_data when DISP_TPG_EN is defined.
module disp_timing_gen_prog
  import disp_timing_gen_prog_pkg::*;
#(
  parameter int CNT_WIDTH     = TG_CNT_W,
  parameter int FRM_CNT_WIDTH = 8,
  parameter int SYNC_ACT_HIGH = 1
) (
  input  logic                     i_clk,
  input  logic                     rst_n,
  input  logic                     i_en,
  input  logic [CNT_WIDTH-1:0]     i_vpulse,
  input  logic [CNT_WIDTH-1:0]     i_vbp,
  input  logic [CNT_WIDTH-1:0]     i_vres,
  input  logic [CNT_WIDTH-1:0]     i_vfp,
  input  logic [CNT_WIDTH-1:0]     i_hpulse,
  input  logic [CNT_WIDTH-1:0]     i_hbp,
  input  logic [CNT_WIDTH-1:0]     i_hres,
  input  logic [CNT_WIDTH-1:0]     i_hfp,
  input  logic [CNT_WIDTH-1:0]     i_PSC,
  input  logic [CNT_WIDTH-1:0]     i_PEC,
  input  logic [CNT_WIDTH-1:0]     i_SR,
  input  logic [CNT_WIDTH-1:0]     i_ER,
  output Vstate_t                  o_Vstate,
  output Hstate_t                  o_Hstate,
  output logic                     o_vsync,
  output logic                     o_hsync,
  output logic                     o_de,
  output logic                     o_pde,
  output logic [CNT_WIDTH-1:0]     o_hcnt,
  output logic [CNT_WIDTH-1:0]     o_vcnt,
`ifdef DISP_TPG_EN
  output logic [23:0]              o_data,
`endif
  output logic                     o_frame_start,
  output logic [FRM_CNT_WIDTH-1:0] o_frame_cnt
);

  localparam logic SYNC_ON = (SYNC_ACT_HIGH != 0);

  timing_cfg_t cfg_in, cfg_q, cfg_d;

  seg_state_t           v_state, v_state_nxt, h_state, h_state_nxt;
  logic [CNT_WIDTH-1:0] v_idx_nxt, h_idx_nxt;
  logic                 v_last, h_last, load, h_halt;

  logic [FRM_CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic                     frame_start_q, frame_start_d;
  logic                     de_q, de_d, pde_q, pde_d;
  logic                     hsync_q, hsync_d, vsync_q, vsync_d;
  logic [CNT_WIDTH-1:0]     hcnt_q, hcnt_d, vcnt_q, vcnt_d;

  assign cfg_in = '{vpulse: i_vpulse, vbp: i_vbp, vres: i_vres, vfp: i_vfp,
                    hpulse: i_hpulse, hbp: i_hbp, hres: i_hres, hfp: i_hfp,
                    psc: i_PSC, pec: i_PEC, sr: i_SR, er: i_ER};

  // v_last already includes the last cycle of the line, so it marks the frame end.
  assign h_halt = v_last & ~i_en;
  assign load   = i_en & ((v_state == IDLE) | v_last);

  disp_seg_cnt #(.W(CNT_WIDTH)) u_hseg (
    .clk       (i_clk),
    .rst_n     (rst_n),
    .start     (i_en),
    .advance   (1'b1),
    .halt      (h_halt),
    .len_pulse (cfg_q.hpulse),
    .len_bp    (cfg_q.hbp),
    .len_act   (cfg_q.hres),
    .len_fp    (cfg_q.hfp),
    .state     (h_state),
    .state_nxt (h_state_nxt),
    .index_nxt (h_idx_nxt),
    .last      (h_last)
  );

  disp_seg_cnt #(.W(CNT_WIDTH)) u_vseg (
    .clk       (i_clk),
    .rst_n     (rst_n),
    .start     (i_en),
    .advance   (h_last),
    .halt      (~i_en),
    .len_pulse (cfg_q.vpulse),
    .len_bp    (cfg_q.vbp),
    .len_act   (cfg_q.vres),
    .len_fp    (cfg_q.vfp),
    .state     (v_state),
    .state_nxt (v_state_nxt),
    .index_nxt (v_idx_nxt),
    .last      (v_last)
  );

  // Window uses cfg_q: on the reload edge the next state is PULSE, so de is 0 anyway.
  always_comb begin
    cfg_d         = load ? cfg_in : cfg_q;
    frame_start_d = load;
    frame_cnt_d   = (v_last && i_en) ? frame_cnt_q + FRM_CNT_WIDTH'(1) : frame_cnt_q;
    de_d          = (v_state_nxt == ACT) && (h_state_nxt == ACT);
    hcnt_d        = de_d ? h_idx_nxt : '0;
    vcnt_d        = de_d ? v_idx_nxt : '0;
    pde_d         = de_d && (hcnt_d >= cfg_q.psc) && (hcnt_d <= cfg_q.pec) &&
                    (vcnt_d >= cfg_q.sr) && (vcnt_d <= cfg_q.er);
    hsync_d       = ((h_state_nxt == PULSE) == SYNC_ON);
    vsync_d       = ((v_state_nxt == PULSE) == SYNC_ON);
  end

`ifdef DISP_TPG_EN
  logic [23:0] data_q, data_d;
  always_comb begin
    data_d = de_d ? {8'(hcnt_d), 8'(vcnt_d), 8'(frame_cnt_d)} : '0;
  end
`endif

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q         <= '0;
      frame_cnt_q   <= '0;
      frame_start_q <= 1'b0;
      de_q          <= 1'b0;
      pde_q         <= 1'b0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      hsync_q       <= ~SYNC_ON;
      vsync_q       <= ~SYNC_ON;
`ifdef DISP_TPG_EN
      data_q        <= '0;
`endif
    end else begin
      cfg_q         <= cfg_d;
      frame_cnt_q   <= frame_cnt_d;
      frame_start_q <= frame_start_d;
      de_q          <= de_d;
      pde_q         <= pde_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
`ifdef DISP_TPG_EN
      data_q        <= data_d;
`endif
    end
  end

  assign o_Vstate      = v_state;
  assign o_Hstate      = h_state;
  assign o_vsync       = vsync_q;
  assign o_hsync       = hsync_q;
  assign o_de          = de_q;
  assign o_pde         = pde_q;
  assign o_hcnt        = hcnt_q;
  assign o_vcnt        = vcnt_q;
  assign o_frame_start = frame_start_q;
  assign o_frame_cnt   = frame_cnt_q;
`ifdef DISP_TPG_EN
  assign o_data        = data_q;
`endif

endmodule

// File: tb/tb_disp_timing_gen_prog.sv
// Directed self-checking bench for disp_timing_gen_prog: frame periods, sync and
// de counts, partial window, shadowing, enable stop/restart and async reset.
module tb_disp_timing_gen_prog;
  import disp_timing_gen_prog_pkg::*;

  localparam int W = 11;

  logic         i_clk = 1'b0;
  logic         rst_n;
  logic         i_en;
  logic [W-1:0] i_vpulse, i_vbp, i_vres, i_vfp;
  logic [W-1:0] i_hpulse, i_hbp, i_hres, i_hfp;
  logic [W-1:0] i_PSC, i_PEC, i_SR, i_ER;
  Vstate_t      o_Vstate;
  Hstate_t      o_Hstate;
  logic         o_vsync, o_hsync, o_de, o_pde, o_frame_start;
  logic [W-1:0] o_hcnt, o_vcnt;
  logic [7:0]   o_frame_cnt;
`ifdef DISP_TPG_EN
  logic [23:0]  o_data;
`endif

  always #5 i_clk = ~i_clk;

  disp_timing_gen_prog dut (
    .i_clk(i_clk), .rst_n(rst_n), .i_en(i_en),
    .i_vpulse(i_vpulse), .i_vbp(i_vbp), .i_vres(i_vres), .i_vfp(i_vfp),
    .i_hpulse(i_hpulse), .i_hbp(i_hbp), .i_hres(i_hres), .i_hfp(i_hfp),
    .i_PSC(i_PSC), .i_PEC(i_PEC), .i_SR(i_SR), .i_ER(i_ER),
    .o_Vstate(o_Vstate), .o_Hstate(o_Hstate),
    .o_vsync(o_vsync), .o_hsync(o_hsync), .o_de(o_de), .o_pde(o_pde),
    .o_hcnt(o_hcnt), .o_vcnt(o_vcnt),
`ifdef DISP_TPG_EN
    .o_data(o_data),
`endif
    .o_frame_start(o_frame_start), .o_frame_cnt(o_frame_cnt)
  );

  int checks = 0;
  int errors = 0;
  int exp_fc;
  int period, n_de, n_hs, n_vs, n_pde, n_hbpfp, n_cnt_out, max_h, max_v, first_de;
  int pde_hmin, pde_hmax, pde_vmin, pde_vmax;
  int n, bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_timing(input int hp, hb, hr, hf, vp, vb, vr, vf);
    i_hpulse = W'(hp); i_hbp = W'(hb); i_hres = W'(hr); i_hfp = W'(hf);
    i_vpulse = W'(vp); i_vbp = W'(vb); i_vres = W'(vr); i_vfp = W'(vf);
  endtask

  task automatic set_win(input int psc, pec, sr, er);
    i_PSC = W'(psc); i_PEC = W'(pec); i_SR = W'(sr); i_ER = W'(er);
  endtask

  task automatic accumulate(input int idx);
    if (o_de) begin
      n_de++;
      if (first_de < 0) first_de = idx;
      if (int'(o_hcnt) > max_h) max_h = int'(o_hcnt);
      if (int'(o_vcnt) > max_v) max_v = int'(o_vcnt);
    end else if (o_hcnt != '0 || o_vcnt != '0) begin
      n_cnt_out++;
    end
    if (o_pde) begin
      n_pde++;
      if (int'(o_hcnt) < pde_hmin) pde_hmin = int'(o_hcnt);
      if (int'(o_hcnt) > pde_hmax) pde_hmax = int'(o_hcnt);
      if (int'(o_vcnt) < pde_vmin) pde_vmin = int'(o_vcnt);
      if (int'(o_vcnt) > pde_vmax) pde_vmax = int'(o_vcnt);
    end
    if (o_hsync) n_hs++;
    if (o_vsync) n_vs++;
    if (o_Hstate == BP || o_Hstate == FP) n_hbpfp++;
  endtask

  // Measures from the current cycle up to (not including) the next frame_start.
  task automatic measure_frame(input string tag, input int limit);
    int k;
    n_de = 0; n_hs = 0; n_vs = 0; n_pde = 0; n_hbpfp = 0; n_cnt_out = 0;
    max_h = -1; max_v = -1; first_de = -1;
    pde_hmin = 99999; pde_hmax = -1; pde_vmin = 99999; pde_vmax = -1;
    k = 0;
    do begin
      accumulate(k);
      step();
      k++;
    end while (!o_frame_start && k < limit);
    period = k;
    check({tag, "_frame_start_seen"}, 32'(o_frame_start), 32'd1);
    exp_fc = (exp_fc + 1) % 256;
    check({tag, "_frame_cnt"}, 32'(o_frame_cnt), 32'(exp_fc));
    $display("frame %s: period=%0d de=%0d hsync=%0d vsync=%0d pde=%0d frame_cnt=%0d",
             tag, period, n_de, n_hs, n_vs, n_pde, o_frame_cnt);
  endtask

  initial begin
    rst_n = 1'b0;
    i_en  = 1'b0;
    set_timing(1, 2, 8, 3, 1, 1, 4, 2);
    set_win(0, 7, 0, 3);
    exp_fc = 0;
    repeat (3) step();

    // Reset state
    check("rst_vstate", 32'(o_Vstate), 32'(IDLE));
    check("rst_hstate", 32'(o_Hstate), 32'(IDLE));
    check("rst_sync_de_pde_fs", {28'd0, o_vsync, o_hsync, o_de, o_pde} | {31'd0, o_frame_start}, 32'd0);
    check("rst_counts", {10'd0, o_hcnt, o_vcnt}, 32'd0);
    check("rst_frame_cnt", 32'(o_frame_cnt), 32'd0);

    #2 rst_n = 1'b1;
    repeat (3) step();
    check("idle_hold_vstate", 32'(o_Vstate), 32'(IDLE));
    check("idle_hold_fs", 32'(o_frame_start), 32'd0);

    // Start from IDLE
    i_en = 1'b1;
    step();
    check("start_fs", 32'(o_frame_start), 32'd1);
    check("start_vstate", 32'(o_Vstate), 32'(PULSE));
    check("start_hstate", 32'(o_Hstate), 32'(PULSE));
    check("start_syncs", {30'd0, o_vsync, o_hsync}, 32'd3);
    check("start_frame_cnt", 32'(o_frame_cnt), 32'd0);

    // Nominal 14x8 frame
    measure_frame("nominal", 400);
    check("nom_period", period, 112);
    check("nom_de", n_de, 32);
    check("nom_hsync", n_hs, 8);
    check("nom_vsync", n_vs, 14);
    check("nom_max_hcnt", max_h, 7);
    check("nom_max_vcnt", max_v, 3);
    check("nom_first_de", first_de, 31);
    check("nom_cnt_outside", n_cnt_out, 0);
    check("nom_pde_full", n_pde, 32);

    // Partial window: takes effect one frame later
    set_win(2, 5, 1, 2);
    measure_frame("win_shadow", 400);
    check("win_shadow_pde", n_pde, 32);
    measure_frame("win", 400);
    check("win_pde", n_pde, 8);
    check("win_hmin", pde_hmin, 2);
    check("win_hmax", pde_hmax, 5);
    check("win_vmin", pde_vmin, 1);
    check("win_vmax", pde_vmax, 2);
    set_win(6, 5, 1, 2);
    measure_frame("win_inv_shadow", 400);
    check("win_inv_shadow_pde", n_pde, 8);
    measure_frame("win_inv", 400);
    check("win_inv_pde", n_pde, 0);

    // Zero-length porches: 9-clock lines, 7-line frame
    set_win(0, 7, 0, 3);
    set_timing(1, 0, 8, 0, 1, 2, 4, 0);
    measure_frame("zero_shadow", 400);
    check("zero_shadow_period", period, 112);
    measure_frame("zero", 400);
    check("zero_period", period, 63);
    check("zero_de", n_de, 32);
    check("zero_hsync", n_hs, 7);
    check("zero_h_bpfp", n_hbpfp, 0);
    check("zero_first_de", first_de, 28);
    check("zero_pde", n_pde, 32);

    set_timing(1, 2, 8, 3, 1, 1, 4, 2);
    measure_frame("restore", 400);
    check("restore_period", period, 63);

    // hres change in line 3 only affects the next frame
    repeat (42) step();
    set_timing(1, 2, 16, 3, 1, 1, 4, 2);
    measure_frame("hres_cur", 400);
    check("hres_cur_period", 42 + period, 112);
    measure_frame("hres_new", 400);
    check("hres_new_period", period, 176);
    check("hres_new_de", n_de, 64);
    check("hres_new_max_hcnt", max_h, 15);
    check("hres_new_pde_clip", n_pde, 32);

    set_timing(1, 2, 8, 3, 1, 1, 4, 2);
    measure_frame("hres_back", 400);
    check("hres_back_period", period, 176);

    // Enable drop mid-ACT: frame completes, then IDLE
    repeat (33) step();
    check("en_mid_de", 32'(o_de), 32'd1);
    check("en_mid_hcnt", 32'(o_hcnt), 32'd2);
    i_en = 1'b0;
    n = 33;
    while (o_Vstate != IDLE && n < 400) begin
      step();
      n++;
    end
    $display("enable drop: idle after %0d cycles", n);
    check("en_idle_at", n, 112);
    check("en_idle_hstate", 32'(o_Hstate), 32'(IDLE));
    check("en_idle_outs", {27'd0, o_vsync, o_hsync, o_de, o_pde, o_frame_start}, 32'd0);
    bad = 0;
    repeat (20) begin
      step();
      if (o_frame_start || o_de || o_hsync || o_vsync || o_Vstate != IDLE) bad++;
    end
    check("en_idle_quiet", bad, 0);
    check("en_idle_frame_cnt", 32'(o_frame_cnt), 32'(exp_fc));
    i_en = 1'b1;
    step();
    check("en_restart_fs", 32'(o_frame_start), 32'd1);
    check("en_restart_vstate", 32'(o_Vstate), 32'(PULSE));
    check("en_restart_frame_cnt", 32'(o_frame_cnt), 32'(exp_fc));
    measure_frame("en_restart", 400);
    check("en_restart_period", period, 112);

    // Asynchronous reset mid-ACT
    repeat (33) step();
    check("rst_mid_de", 32'(o_de), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_outs", {28'd0, o_vsync, o_hsync, o_de, o_pde}, 32'd0);
    check("arst_states", {26'd0, o_Vstate, o_Hstate}, {26'd0, IDLE, IDLE});
    check("arst_counts", {10'd0, o_hcnt, o_vcnt}, 32'd0);
    check("arst_frame_cnt", 32'(o_frame_cnt), 32'd0);
    #2 rst_n = 1'b1;
    exp_fc = 0;
    n = 0;
    do begin
      step();
      n++;
    end while (!o_frame_start && n < 5);
    check("arst_restart_fs", 32'(o_frame_start), 32'd1);
    measure_frame("arst_restart", 400);
    check("arst_restart_period", period, 112);
    check("arst_restart_de", n_de, 32);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
